dac_sample_scheduler: RTL and testbench

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

---
 rtl/dac_sample_scheduler.sv | 176 +++++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// Buffers producer DAC codes and releases one per PWM window on the next_sample strobe.
// Latency: a popped code appears on `code` the cycle after the strobe; underrun pulses the cycle after a starved strobe.
// Backpressure: in_ready = (fifo_count < FIFO_DEPTH), taken from registered occupancy only (no path from next_sample).
// Optional feature: define DAC_UNDERRUN_COUNT_EN to add the 16-bit saturating underrun_count output.
module dac_sample_scheduler #(
    parameter int CYCLES_PER_WINDOW = 1024,
    parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
    parameter int FIFO_DEPTH        = 4,
    parameter int PRIME_LEVEL       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [CODE_WIDTH-1:0]         in_code,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          next_sample,
    output logic [CODE_WIDTH-1:0]         code,
    output logic                          running,
    output logic                          underrun,
`ifdef DAC_UNDERRUN_COUNT_EN
    output logic [15:0]                   underrun_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CODE_WIDTH-1:0]  code_q, code_d;
    logic                   underrun_q, underrun_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CODE_WIDTH-1:0]  mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   fifo_nonempty;
    logic                   primed;

    assign fifo_nonempty = (count_q != '0);
    assign primed        = (count_q >= CNT_W'(PRIME_LEVEL));
    assign in_ready      = (count_q < CNT_W'(FIFO_DEPTH));
    assign push          = in_valid && in_ready;

    // State register: reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: disable wins over a strobe; a starved strobe in RUN falls back to PRIME.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable)                    state_d = ST_IDLE;
                else if (next_sample && primed) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)                            state_d = ST_IDLE;
                else if (next_sample && !fifo_nonempty) state_d = ST_PRIME;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: decide the pop, the next DAC code and the underrun pulse.
    always_comb begin
        pop        = 1'b0;
        code_d     = code_q;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                code_d = '0;
            end
            ST_PRIME: begin
                if (!enable) begin
                    code_d = '0;
                end else if (next_sample && primed) begin
                    pop    = 1'b1;
                    code_d = mem_q[rd_ptr_q];
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    code_d = '0;
                end else if (next_sample) begin
                    if (fifo_nonempty) begin
                        pop    = 1'b1;
                        code_d = mem_q[rd_ptr_q];
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: code_d = '0;
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth; push+pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Datapath registers: reset discards buffered samples and silences the DAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q     <= '0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            code_q     <= code_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Sample storage: contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= in_code;
        end
    end

`ifdef DAC_UNDERRUN_COUNT_EN
    logic [15:0] urun_cnt_q, urun_cnt_d;

    // Underrun counter next value: saturates rather than wrapping.
    always_comb begin
        urun_cnt_d = urun_cnt_q;
        if (underrun_d && (urun_cnt_q != 16'hFFFF)) urun_cnt_d = urun_cnt_q + 16'd1;
    end

    // Underrun counter register: cleared only by reset, never by enable.
    always_ff @(posedge clk) begin
        if (rst) urun_cnt_q <= '0;
        else     urun_cnt_q <= urun_cnt_d;
    end

    assign underrun_count = urun_cnt_q;
`endif

    assign code       = code_q;
    assign underrun   = underrun_q;
    assign running    = (state_q == ST_RUN);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler with default parameters.
// Inputs change 1 time unit after posedge; outputs are checked at that same point.
// A queue tracks samples accepted by the FIFO; expected codes are queued at the strobe and compared after it.
module tb_dac_sample_scheduler;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] in_code = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          next_sample = 1'b0;
    logic [CW-1:0] code;
    logic          running;
    logic          underrun;
    logic [2:0]    fifo_count;
`ifdef DAC_UNDERRUN_COUNT_EN
    logic [15:0]   underrun_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0] sb [$];     // samples the DUT FIFO should hold, oldest first
    logic [CW-1:0] exp_q [$];  // codes expected on `code` after pending strobes

    dac_sample_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_code     (in_code),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .next_sample (next_sample),
        .code        (code),
        .running     (running),
        .underrun    (underrun),
`ifdef DAC_UNDERRUN_COUNT_EN
        .underrun_count (underrun_count),
`endif
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; expects a pop when exp_pop is set and checks code/occupancy afterwards.
    task automatic step(input bit v, input logic [CW-1:0] c, input bit ns, input bit exp_pop);
        bit acc;
        in_valid    = v;
        in_code     = c;
        next_sample = ns;
        acc = v && (sb.size() < 4);
        if (exp_pop && sb.size() > 0) exp_q.push_back(sb.pop_front());
        if (acc) sb.push_back(c);
        tick();
        in_valid    = 1'b0;
        next_sample = 1'b0;
        if (exp_pop) begin
            if (exp_q.size() > 0) chk("pop_code", code, exp_q.pop_front());
            else                  chk("pop_expected_sample", 0, 1);
        end
        chk("fifo_count", fifo_count, sb.size());
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_code", code, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_running", running, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef DAC_UNDERRUN_COUNT_EN
        chk("rst_urun_cnt", underrun_count, 0);
`endif

        // Normal playback: three samples released one per 1024-cycle window
        enable = 1'b1;
        tick();
        step(1, 10'd10, 0, 0);
        step(1, 10'd20, 0, 0);
        step(1, 10'd30, 0, 0);
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1023);
            step(0, '0, 1, 1);
            chk("run_running", running, 1);
        end

        // Starved strobe in RUN: code holds, one-cycle underrun, back to PRIME
        wait_cycles(5);
        step(0, '0, 1, 0);
        chk("urun_code_hold", code, 30);
        chk("urun_pulse", underrun, 1);
        chk("urun_running", running, 0);
`ifdef DAC_UNDERRUN_COUNT_EN
        chk("urun_cnt", underrun_count, 1);
`endif
        tick();
        chk("urun_pulse_end", underrun, 0);

        // Priming threshold of two samples
        step(1, 10'd55, 0, 0);
        step(0, '0, 1, 0);
        chk("prime_code_hold", code, 30);
        chk("prime_running", running, 0);
        step(1, 10'd66, 0, 0);
        step(0, '0, 1, 1);
        chk("prime_run", running, 1);

        // Push and pop in the same cycle
        step(1, 10'd77, 1, 1);
        step(1, 10'd88, 0, 0);
        step(1, 10'd99, 0, 0);

        // Disable with three buffered, strobe in the same cycle is ignored
        enable = 1'b0;
        step(0, '0, 1, 0);
        chk("dis_code", code, 0);
        chk("dis_running", running, 0);
        enable = 1'b1;
        step(0, '0, 0, 0);
        chk("reen_code", code, 0);
        step(0, '0, 1, 1);
        chk("reen_running", running, 1);

        // Fill to full while idle; a push while full is refused
        enable = 1'b0;
        step(0, '0, 0, 0);
        step(1, 10'd100, 0, 0);
        step(1, 10'd101, 0, 0);
        chk("full_in_ready", in_ready, 0);
        step(1, 10'd102, 1, 0);
        chk("full_idle_code", code, 0);
        chk("full_in_ready2", in_ready, 0);
        enable = 1'b1;
        step(1, 10'd103, 0, 0);
        step(1, 10'd104, 1, 1);
        chk("full_pop_in_ready", in_ready, 1);

        // Reset mid-run overrides strobe and push
        rst = 1'b1;
        in_valid = 1'b1;
        in_code = 10'd200;
        next_sample = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        next_sample = 1'b0;
        sb.delete();
        chk("mrst_code", code, 0);
        chk("mrst_count", fifo_count, 0);
        chk("mrst_running", running, 0);
        chk("mrst_underrun", underrun, 0);
        chk("mrst_in_ready", in_ready, 1);
`ifdef DAC_UNDERRUN_COUNT_EN
        chk("mrst_urun_cnt", underrun_count, 0);
`endif

        // Playback resumes cleanly after reset
        tick();
        step(1, 10'd5, 0, 0);
        step(1, 10'd6, 0, 0);
        step(0, '0, 1, 1);
        chk("post_rst_running", running, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
